ddr5_dfi_write_sequencer: RTL

//  Upstream DFI write-command sequencer feeding the DDR5 PHY write path. Accepts write requests
//  (2-word CA command + target rank) and per-clock write data over valid/ready handshakes.

---
 rtl/ddr5_dfi_write_sequencer_if.sv | 50 +++++
 rtl/ddr5_dfi_write_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ddr5_dfi_write_sequencer_if.sv
// Request/write-data handshakes and the 1:4 DFI write-path bus of ddr5_dfi_write_sequencer.
// master = upstream requester / PHY side, slave = the sequencer.
interface ddr5_dfi_write_sequencer_if #(
  parameter int unsigned pDRAM_SIZE = 4,
  parameter int unsigned pNUM_RANK  = 2
);
  localparam int unsigned RankW = (pNUM_RANK > 1) ? $clog2(pNUM_RANK) : 1;
  localparam int unsigned DataW = 2 * pDRAM_SIZE;
  localparam int unsigned MaskW = pDRAM_SIZE / 4;

  logic                   req_valid_i;
  logic                   req_ready_o;
  logic [RankW-1:0]       req_rank_i;
  logic [13:0]            req_ca0_i;
  logic [13:0]            req_ca1_i;
  logic                   wdata_valid_i;
  logic                   wdata_ready_o;
  logic [4*DataW-1:0]     wdata_i;
  logic [4*MaskW-1:0]     wmask_i;

  logic [pNUM_RANK-1:0]   dfi_cs_n_p0, dfi_cs_n_p1, dfi_cs_n_p2, dfi_cs_n_p3;
  logic [pNUM_RANK-1:0]   dfi_reset_n_p0, dfi_reset_n_p1, dfi_reset_n_p2, dfi_reset_n_p3;
  logic [13:0]            dfi_address_p0, dfi_address_p1, dfi_address_p2, dfi_address_p3;
  logic                   dfi_wrdata_en_p0, dfi_wrdata_en_p1, dfi_wrdata_en_p2, dfi_wrdata_en_p3;
  logic [DataW-1:0]       dfi_wrdata_p0, dfi_wrdata_p1, dfi_wrdata_p2, dfi_wrdata_p3;
  logic [MaskW-1:0]       dfi_wrdata_mask_p0, dfi_wrdata_mask_p1;
  logic [MaskW-1:0]       dfi_wrdata_mask_p2, dfi_wrdata_mask_p3;

  modport master (
    output req_valid_i, req_rank_i, req_ca0_i, req_ca1_i, wdata_valid_i, wdata_i, wmask_i,
    input  req_ready_o, wdata_ready_o,
    input  dfi_cs_n_p0, dfi_cs_n_p1, dfi_cs_n_p2, dfi_cs_n_p3,
    input  dfi_reset_n_p0, dfi_reset_n_p1, dfi_reset_n_p2, dfi_reset_n_p3,
    input  dfi_address_p0, dfi_address_p1, dfi_address_p2, dfi_address_p3,
    input  dfi_wrdata_en_p0, dfi_wrdata_en_p1, dfi_wrdata_en_p2, dfi_wrdata_en_p3,
    input  dfi_wrdata_p0, dfi_wrdata_p1, dfi_wrdata_p2, dfi_wrdata_p3,
    input  dfi_wrdata_mask_p0, dfi_wrdata_mask_p1, dfi_wrdata_mask_p2, dfi_wrdata_mask_p3
  );

  modport slave (
    input  req_valid_i, req_rank_i, req_ca0_i, req_ca1_i, wdata_valid_i, wdata_i, wmask_i,
    output req_ready_o, wdata_ready_o,
    output dfi_cs_n_p0, dfi_cs_n_p1, dfi_cs_n_p2, dfi_cs_n_p3,
    output dfi_reset_n_p0, dfi_reset_n_p1, dfi_reset_n_p2, dfi_reset_n_p3,
    output dfi_address_p0, dfi_address_p1, dfi_address_p2, dfi_address_p3,
    output dfi_wrdata_en_p0, dfi_wrdata_en_p1, dfi_wrdata_en_p2, dfi_wrdata_en_p3,
    output dfi_wrdata_p0, dfi_wrdata_p1, dfi_wrdata_p2, dfi_wrdata_p3,
    output dfi_wrdata_mask_p0, dfi_wrdata_mask_p1, dfi_wrdata_mask_p2, dfi_wrdata_mask_p3
  );
endinterface

// File: rtl/ddr5_dfi_write_sequencer.sv
// DDR5 DFI 1:4 write-command sequencer with a write-data FIFO and registered DFI outputs.
// Define DDR5_SEQ_WR_CNT_EN to add a saturating completed-write counter on wr_count_o.
module ddr5_dfi_write_sequencer #(
  parameter int unsigned pDRAM_SIZE  = 4,
  parameter int unsigned pNUM_RANK   = 2,
  parameter int unsigned pWRLAT      = 4,
  parameter int unsigned pBURST_CYC  = 2,
  parameter int unsigned pFIFO_DEPTH = 4,
  parameter int unsigned pRESET_CYC  = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  ddr5_dfi_write_sequencer_if.slave  seq_if,
`ifdef DDR5_SEQ_WR_CNT_EN
  output logic [15:0]                wr_count_o,
`endif
  output logic                       busy_o
);
  localparam int unsigned DataW = 2 * pDRAM_SIZE;
  localparam int unsigned MaskW = pDRAM_SIZE / 4;
  localparam int unsigned PtrW  = (pFIFO_DEPTH > 1) ? $clog2(pFIFO_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(pFIFO_DEPTH + 1);
  localparam int unsigned InitW = $clog2(pRESET_CYC + 1);
  localparam int unsigned WaitW = $clog2(pWRLAT + 1);
  localparam int unsigned BeatW = (pBURST_CYC > 1) ? $clog2(pBURST_CYC) : 1;
  localparam logic [13:0] CaNop = 14'h3FFF;

  typedef enum logic [2:0] {StInit, StIdle, StCmd, StWait, StData, StGap} state_e;

  state_e                        state_q;
  logic [InitW-1:0]              init_cnt_q;
  logic [WaitW-1:0]              wait_cnt_q;
  logic [BeatW-1:0]              beat_q;
  logic [3:0][pNUM_RANK-1:0]     cs_n_q, reset_n_q;
  logic [3:0][13:0]              addr_q;
  logic [3:0]                    wren_q;
  logic [3:0][DataW-1:0]         wrdata_q;
  logic [3:0][MaskW-1:0]         mask_q;

  logic [4*DataW-1:0]            fifo_data_q [pFIFO_DEPTH];
  logic [4*MaskW-1:0]            fifo_mask_q [pFIFO_DEPTH];
  logic [PtrW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]               count_q;

  logic wdata_ready, req_ready, push, pop, req_fire, last_beat;

  assign wdata_ready = (state_q != StInit) && (count_q < CntW'(pFIFO_DEPTH));
  assign req_ready   = (state_q == StIdle) && (count_q >= CntW'(pBURST_CYC));
  assign push        = seq_if.wdata_valid_i && wdata_ready;
  assign req_fire    = seq_if.req_valid_i && req_ready;
  assign last_beat   = (beat_q == BeatW'(pBURST_CYC - 1));
  // Pop on the edge that enters each DATA clock so the popped beat is on the bus that clock.
  assign pop = ((state_q == StCmd) && (pWRLAT == 1)) ||
               ((state_q == StWait) && (wait_cnt_q == WaitW'(1))) ||
               ((state_q == StData) && !last_beat);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(pFIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
      beat_q     <= '0;
      cs_n_q     <= '1;
      reset_n_q  <= '0;
      addr_q     <= '0;
      wren_q     <= '0;
      wrdata_q   <= '0;
      mask_q     <= '0;
    end else begin
      cs_n_q   <= '1;
      addr_q   <= {4{CaNop}};
      wren_q   <= '0;
      wrdata_q <= '0;
      mask_q   <= '0;
      if (pop) begin
        wren_q   <= '1;
        wrdata_q <= fifo_data_q[rd_ptr_q];
        mask_q   <= fifo_mask_q[rd_ptr_q];
      end
      unique case (state_q)
        StInit: begin
          if (init_cnt_q == InitW'(pRESET_CYC - 1)) begin
            reset_n_q <= '1;
            state_q   <= StIdle;
          end else begin
            init_cnt_q <= init_cnt_q + InitW'(1);
          end
        end
        StIdle: begin
          if (req_fire) begin
            cs_n_q[0] <= ~(pNUM_RANK'(1) << seq_if.req_rank_i);
            addr_q[0] <= seq_if.req_ca0_i;
            addr_q[1] <= seq_if.req_ca1_i;
            state_q   <= StCmd;
          end
        end
        StCmd: begin
          beat_q <= '0;
          if (pWRLAT == 1) begin
            state_q <= StData;
          end else begin
            wait_cnt_q <= WaitW'(pWRLAT - 1);
            state_q    <= StWait;
          end
        end
        StWait: begin
          wait_cnt_q <= wait_cnt_q - WaitW'(1);
          if (wait_cnt_q == WaitW'(1)) state_q <= StData;
        end
        StData: begin
          if (last_beat) state_q <= StGap;
          else           beat_q  <= beat_q + BeatW'(1);
        end
        StGap:   state_q <= StIdle;
        default: state_q <= StInit;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= seq_if.wdata_i;
      fifo_mask_q[wr_ptr_q] <= seq_if.wmask_i;
    end
  end

`ifdef DDR5_SEQ_WR_CNT_EN
  logic [15:0] wr_cnt_q;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_cnt_q <= '0;
    end else if ((state_q == StData) && last_beat && (wr_cnt_q != 16'hFFFF)) begin
      wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end
  assign wr_count_o = wr_cnt_q;
`endif

  assign busy_o               = state_q inside {StCmd, StWait, StData, StGap};
  assign seq_if.req_ready_o   = req_ready;
  assign seq_if.wdata_ready_o = wdata_ready;

  assign seq_if.dfi_cs_n_p0        = cs_n_q[0];
  assign seq_if.dfi_cs_n_p1        = cs_n_q[1];
  assign seq_if.dfi_cs_n_p2        = cs_n_q[2];
  assign seq_if.dfi_cs_n_p3        = cs_n_q[3];
  assign seq_if.dfi_reset_n_p0     = reset_n_q[0];
  assign seq_if.dfi_reset_n_p1     = reset_n_q[1];
  assign seq_if.dfi_reset_n_p2     = reset_n_q[2];
  assign seq_if.dfi_reset_n_p3     = reset_n_q[3];
  assign seq_if.dfi_address_p0     = addr_q[0];
  assign seq_if.dfi_address_p1     = addr_q[1];
  assign seq_if.dfi_address_p2     = addr_q[2];
  assign seq_if.dfi_address_p3     = addr_q[3];
  assign seq_if.dfi_wrdata_en_p0   = wren_q[0];
  assign seq_if.dfi_wrdata_en_p1   = wren_q[1];
  assign seq_if.dfi_wrdata_en_p2   = wren_q[2];
  assign seq_if.dfi_wrdata_en_p3   = wren_q[3];
  assign seq_if.dfi_wrdata_p0      = wrdata_q[0];
  assign seq_if.dfi_wrdata_p1      = wrdata_q[1];
  assign seq_if.dfi_wrdata_p2      = wrdata_q[2];
  assign seq_if.dfi_wrdata_p3      = wrdata_q[3];
  assign seq_if.dfi_wrdata_mask_p0 = mask_q[0];
  assign seq_if.dfi_wrdata_mask_p1 = mask_q[1];
  assign seq_if.dfi_wrdata_mask_p2 = mask_q[2];
  assign seq_if.dfi_wrdata_mask_p3 = mask_q[3];
endmodule
